// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if: fetch request/response and memory word-read signals of icache_ctrl.
interface icache_ctrl_if #(
  parameter int WORD_SIZE = 32,
  parameter int BLOCK_SIZE = 1024
);
  logic req_valid, req_ready, resp_valid, miss, mem_req, mem_rvalid;
  logic [WORD_SIZE-1:0] req_addr, mem_addr, mem_rdata;
  logic [BLOCK_SIZE-1:0] resp_block;
  modport master(
    output req_valid, req_addr, mem_rvalid, mem_rdata,
    input req_ready, resp_valid, resp_block, miss, mem_req, mem_addr
  );
  modport slave(
    input req_valid, req_addr, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_block, miss, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache returning whole lines, filled word by word from memory.
module icache_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int BLOCK_SIZE = 1024,
  parameter int LINES = 4
) (
  input logic clk,
  input logic rst_n,
  icache_ctrl_if.slave bus
);
  localparam int WORDS = BLOCK_SIZE / WORD_SIZE;
  localparam int OFF = $clog2(BLOCK_SIZE / 8);
  localparam int IW = $clog2(LINES);
  localparam int CW = $clog2(WORDS);
  localparam int TW = WORD_SIZE - OFF - IW;
  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
  state_t state, state_nx;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0] tag_q [LINES];
  logic [BLOCK_SIZE-1:0] data_q [LINES];
  logic [BLOCK_SIZE-1:0] buf_q, buf_nx, resp_block_q;
  logic [WORD_SIZE-OFF-1:0] base_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] req_idx, fill_idx;
  logic [TW-1:0] req_tag, fill_tag;
  logic hit, hit_take, miss_take, beat, last, resp_valid_q;
  assign req_idx = bus.req_addr[OFF +: IW];
  assign req_tag = bus.req_addr[WORD_SIZE-1 -: TW];
  assign fill_idx = base_q[IW-1:0];
  assign fill_tag = base_q[WORD_SIZE-OFF-1 -: TW];
  assign hit = valid_q[req_idx] && tag_q[req_idx] == req_tag;
  assign hit_take = state == IDLE && bus.req_valid && hit;
  assign miss_take = state == IDLE && bus.req_valid && !hit;
  assign beat = state == FILL && bus.mem_rvalid;
  assign last = beat && &cnt_q;
  assign bus.req_ready = state == IDLE;
  assign bus.miss = state == FILL;
  assign bus.mem_req = state == FILL;
  assign bus.mem_addr = {base_q, cnt_q, {(OFF-CW){1'b0}}};
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_block = resp_block_q;
  always_comb begin
    state_nx = state;
    if (miss_take) state_nx = FILL;
    else if (last) state_nx = RESP;
    else if (state == RESP) state_nx = IDLE;
  end
  // Fill buffer with the returning word merged in, so the last beat can be written straight to the line.
  always_comb begin
    buf_nx = buf_q;
    buf_nx[(WORDS-1-int'(cnt_q))*WORD_SIZE +: WORD_SIZE] = bus.mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      cnt_q <= '0;
      base_q <= '0;
      resp_valid_q <= 1'b0;
      resp_block_q <= '0;
    end else begin
      resp_valid_q <= hit_take || last;
      if (hit_take) resp_block_q <= data_q[req_idx];
      else if (last) resp_block_q <= buf_nx;
      if (miss_take) begin
        base_q <= bus.req_addr[WORD_SIZE-1:OFF];
        cnt_q <= '0;
      end else if (beat) cnt_q <= cnt_q + 1'b1;
      if (last) valid_q[fill_idx] <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (beat) buf_q <= buf_nx;
    if (last) begin
      data_q[fill_idx] <= buf_nx;
      tag_q[fill_idx] <= fill_tag;
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed table, corner sequences and random fetches against a line-address cache model.
module tb_icache_ctrl;
  localparam int W = 32, B = 1024, L = 4;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  icache_ctrl_if #(.WORD_SIZE(W), .BLOCK_SIZE(B)) bus ();
  icache_ctrl #(.WORD_SIZE(W), .BLOCK_SIZE(B), .LINES(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, failures = 0;
  logic [W-1:0] line_base [L];
  bit line_ok [L];
  typedef struct { logic [W-1:0] addr; int stall; bit noise; bit hit; } vec_t;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic chk_blk(input string n, input logic [B-1:0] a, input logic [B-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      for (int k = 0; k < B / W; k++)
        if (a[B-1-W*k -: W] !== e[B-1-W*k -: W]) begin
          $display("FAIL %s word %0d got=%0h exp=%0h", n, k, a[B-1-W*k -: W], e[B-1-W*k -: W]);
          break;
        end
    end
  endtask
  function automatic logic [W-1:0] memw(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction
  function automatic logic [B-1:0] blk(input logic [W-1:0] base);
    logic [B-1:0] b;
    for (int k = 0; k < B / W; k++) b[B-1-W*k -: W] = memw(base + 32'(4 * k));
    return b;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_beat(input logic [W-1:0] base, input int k, input int stall, input bit noise);
    logic [W-1:0] ea;
    ea = base + 32'(4 * k);
    for (int s = 0; s < stall; s++) begin
      bus.req_valid = noise;
      bus.req_addr = $urandom;
      chk("mem_addr_stall", bus.mem_addr, ea);
      chk("mem_req_stall", bus.mem_req, 1);
      chk("miss_stall", bus.miss, 1);
      chk("no_resp_stall", bus.resp_valid, 0);
      cyc();
    end
    bus.req_valid = 1'b0;
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_req", bus.mem_req, 1);
    chk("no_resp_fill", bus.resp_valid, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = memw(ea);
    cyc();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = $urandom;
  endtask
  task automatic fetch(input logic [W-1:0] addr, input int stall, input bit rnd, input bit noise, input bit exp_hit);
    logic [W-1:0] base;
    int idx;
    base = addr & ~32'h7F;
    idx = int'(addr[8:7]);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr = addr;
    cyc();
    bus.req_valid = 1'b0;
    bus.req_addr = $urandom;
    chk("hit_resp", bus.resp_valid, exp_hit);
    chk("miss_flag", bus.miss, !exp_hit);
    if (!exp_hit) begin
      for (int k = 0; k < B / W; k++)
        do_beat(base, k, rnd ? int'($urandom_range(0, stall)) : stall, noise);
      chk("resp_after_fill", bus.resp_valid, 1);
      chk("miss_in_resp", bus.miss, 0);
      chk("mem_req_in_resp", bus.mem_req, 0);
      chk("ready_in_resp", bus.req_ready, 0);
      line_base[idx] = base;
      line_ok[idx] = 1'b1;
    end else chk("mem_req_on_hit", bus.mem_req, 0);
    chk_blk(exp_hit ? "hit_block" : "fill_block", bus.resp_block, blk(base));
    cyc();
    chk("resp_pulse_end", bus.resp_valid, 0);
    chk_blk("block_hold", bus.resp_block, blk(base));
  endtask
  initial begin
    #5_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    vec_t vecs [8];
    logic [W-1:0] a, base;
    int idx;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < L; i++) line_ok[i] = 1'b0;
    #1 rst_n = 1'b0;
    cyc();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_miss", bus.miss, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk_blk("rst_resp_block", bus.resp_block, '0);
    rst_n = 1'b1;
    cyc();
    vecs = '{
      '{32'h0000_0080, 0, 1'b0, 1'b0},
      '{32'h0000_00A4, 0, 1'b0, 1'b1},
      '{32'h0000_0280, 0, 1'b0, 1'b0},
      '{32'h0000_0080, 0, 1'b0, 1'b0},
      '{32'h0000_0100, 5, 1'b0, 1'b0},
      '{32'h0000_017C, 0, 1'b0, 1'b1},
      '{32'h0000_3180, 1, 1'b1, 1'b0},
      '{32'h0000_00FC, 0, 1'b0, 1'b1}
    };
    foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].stall, 1'b0, vecs[i].noise, vecs[i].hit);
    for (int i = 0; i < 3; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = $urandom;
      cyc();
      chk("stray_no_req", bus.mem_req, 0);
      chk("stray_no_resp", bus.resp_valid, 0);
      chk("stray_ready", bus.req_ready, 1);
    end
    bus.mem_rvalid = 1'b0;
    fetch(32'h0000_0080, 0, 1'b0, 1'b0, 1'b1);
    fetch(32'h0000_4000, 0, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h0000_0300;
    cyc();
    bus.req_valid = 1'b0;
    chk("abort_miss", bus.miss, 1);
    for (int k = 0; k < 10; k++) do_beat(32'h0000_0300, k, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", bus.req_ready, 1);
    chk("abort_resp_valid", bus.resp_valid, 0);
    chk("abort_miss_low", bus.miss, 0);
    chk("abort_mem_req", bus.mem_req, 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk_blk("abort_resp_block", bus.resp_block, '0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < L; i++) line_ok[i] = 1'b0;
    cyc();
    fetch(32'h0000_0300, 0, 1'b0, 1'b0, 1'b0);
    fetch(32'h0000_0080, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 2) << 9) | ($urandom_range(0, 3) << 7) | $urandom_range(0, 127);
      base = a & ~32'h7F;
      idx = int'(a[8:7]);
      fetch(a, 2, 1'b1, 1'($urandom_range(0, 1)), line_ok[idx] && line_base[idx] == base);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
